// File: rtl/wb_initiator_pkg.sv
// Shared definitions for the Wishbone B4 pipelined initiator and its subordinate-side users.
// Contents:
//   - default parameter constants (address/data width, select granularity, timeout)
//   - wb_state_e : transaction FSM states
//   - timeout_cnt_width() : width of a saturating counter able to hold 0..cycles
package wb_initiator_pkg;

    localparam int unsigned WbAddressWidthDefault    = 32;
    localparam int unsigned WbDataWidthDefault       = 32;
    localparam int unsigned WbDataGranularityDefault = 8;
    localparam int unsigned TimeoutCyclesDefault     = 255;

    typedef enum logic [1:0] {
        StIdle,
        StRequest,
        StWaitAck,
        StRespond
    } wb_state_e;

    // Never narrower than one bit, even for a degenerate zero timeout.
    function automatic int unsigned timeout_cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/wb_initiator_interface_if.sv
// Bundle of the command, response and Wishbone bus signals of the initiator.
// Modports:
//   master : the initiator's view (drives o_* signals, samples i_* signals)
//   slave  : the surrounding environment's view (command source, response sink, Wishbone
//            subordinate)
// Signals:
//   i_cmd_valid/o_cmd_ready/i_cmd_we/i_cmd_addr/i_cmd_wdata/i_cmd_sel : command channel
//   o_rsp_valid/i_rsp_ready/o_rsp_rdata/o_rsp_err/o_rsp_timeout       : response channel
//   o_wb_cyc/o_wb_stb/o_wb_we/o_wb_addr/o_wb_dat/o_wb_sel             : Wishbone request
//   i_wb_dat/i_wb_stall/i_wb_ack/i_wb_err                             : Wishbone reply
interface wb_initiator_interface_if
    import wb_initiator_pkg::*;
#(
    parameter int unsigned WB_ADDRESS_WIDTH    = WbAddressWidthDefault,
    parameter int unsigned WB_DATA_WIDTH       = WbDataWidthDefault,
    parameter int unsigned WB_DATA_GRANULARITY = WbDataGranularityDefault
);
    localparam int unsigned WB_SEL_WIDTH = WB_DATA_WIDTH / WB_DATA_GRANULARITY;

    logic                        i_cmd_valid;
    logic                        o_cmd_ready;
    logic                        i_cmd_we;
    logic [WB_ADDRESS_WIDTH-1:0] i_cmd_addr;
    logic [WB_DATA_WIDTH-1:0]    i_cmd_wdata;
    logic [WB_SEL_WIDTH-1:0]     i_cmd_sel;

    logic                        o_rsp_valid;
    logic                        i_rsp_ready;
    logic [WB_DATA_WIDTH-1:0]    o_rsp_rdata;
    logic                        o_rsp_err;
    logic                        o_rsp_timeout;

    logic                        o_wb_cyc;
    logic                        o_wb_stb;
    logic                        o_wb_we;
    logic [WB_ADDRESS_WIDTH-1:0] o_wb_addr;
    logic [WB_DATA_WIDTH-1:0]    o_wb_dat;
    logic [WB_SEL_WIDTH-1:0]     o_wb_sel;
    logic [WB_DATA_WIDTH-1:0]    i_wb_dat;
    logic                        i_wb_stall;
    logic                        i_wb_ack;
    logic                        i_wb_err;

    modport master (
        input  i_cmd_valid, i_cmd_we, i_cmd_addr, i_cmd_wdata, i_cmd_sel,
        output o_cmd_ready,
        input  i_rsp_ready,
        output o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_dat, o_wb_sel,
        input  i_wb_dat, i_wb_stall, i_wb_ack, i_wb_err
    );

    modport slave (
        output i_cmd_valid, i_cmd_we, i_cmd_addr, i_cmd_wdata, i_cmd_sel,
        input  o_cmd_ready,
        output i_rsp_ready,
        input  o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_dat, o_wb_sel,
        output i_wb_dat, i_wb_stall, i_wb_ack, i_wb_err
    );

endinterface

// File: rtl/wb_initiator_interface.sv
// Single-outstanding Wishbone B4 pipelined initiator.
// A command accepted on the valid/ready handshake is issued as one Wishbone cycle; the ACK,
// ERR or a timeout ends the cycle and produces one response that is held until accepted.
// Ports:
//   i_wb_clk : clock
//   i_wb_rst : asynchronous active-high reset (abandons any transaction in flight)
//   o_busy   : high whenever a transaction is in progress (state not idle)
//   bus      : command, response and Wishbone signals (wb_initiator_interface_if.master)
module wb_initiator_interface
    import wb_initiator_pkg::*;
#(
    parameter int unsigned WB_ADDRESS_WIDTH    = WbAddressWidthDefault,
    parameter int unsigned WB_DATA_WIDTH       = WbDataWidthDefault,
    parameter int unsigned WB_DATA_GRANULARITY = WbDataGranularityDefault,
    parameter int unsigned TIMEOUT_CYCLES      = TimeoutCyclesDefault
) (
    input  logic i_wb_clk,
    input  logic i_wb_rst,
    output logic o_busy,
    wb_initiator_interface_if.master bus
);

    localparam int unsigned WB_SEL_WIDTH = WB_DATA_WIDTH / WB_DATA_GRANULARITY;
    localparam int unsigned CntW         = timeout_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT_CYCLES);

    wb_state_e                   state_q;
    logic                        cyc_q;
    logic                        stb_q;
    logic                        we_q;
    logic [WB_ADDRESS_WIDTH-1:0] addr_q;
    logic [WB_DATA_WIDTH-1:0]    wdata_q;
    logic [WB_SEL_WIDTH-1:0]     sel_q;
    logic                        rsp_valid_q;
    logic [WB_DATA_WIDTH-1:0]    rsp_rdata_q;
    logic                        rsp_err_q;
    logic                        rsp_timeout_q;
    logic [CntW-1:0]             cnt_q;
    logic [CntW-1:0]             cnt_d;

    logic issued;
    logic reply_seen;
    logic timeout_hit;

    always_comb begin
        // Saturating increment: the counter never wraps.
        cnt_d = (cnt_q == CntLimit) ? cnt_q : cnt_q + CntW'(1);

        // The subordinate only owns the request once STB is taken without stall; a reply
        // seen earlier (during a stalled request) belongs to nothing and is ignored.
        issued      = ((state_q == StRequest) && !bus.i_wb_stall) || (state_q == StWaitAck);
        reply_seen  = issued && (bus.i_wb_ack || bus.i_wb_err);
        // This is the TIMEOUT_CYCLES-th cycle with CYC high and no reply arrived.
        timeout_hit = cyc_q && (cnt_d == CntLimit);
    end

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            state_q       <= StIdle;
            cyc_q         <= 1'b0;
            stb_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            sel_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.i_cmd_valid) begin
                        we_q    <= bus.i_cmd_we;
                        addr_q  <= bus.i_cmd_addr;
                        wdata_q <= bus.i_cmd_wdata;
                        sel_q   <= bus.i_cmd_sel;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= StRequest;
                    end
                end

                StRequest, StWaitAck: begin
                    cnt_q <= cnt_d;
                    if ((state_q == StRequest) && !bus.i_wb_stall) begin
                        stb_q <= 1'b0;
                    end
                    if (reply_seen) begin
                        // ERR wins over a simultaneous ACK.
                        cyc_q         <= 1'b0;
                        stb_q         <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b0;
                        rsp_err_q     <= bus.i_wb_err;
                        rsp_rdata_q   <= (bus.i_wb_err || we_q) ? '0 : bus.i_wb_dat;
                        state_q       <= StRespond;
                    end else if (timeout_hit) begin
                        cyc_q         <= 1'b0;
                        stb_q         <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_err_q     <= 1'b0;
                        rsp_rdata_q   <= '0;
                        state_q       <= StRespond;
                    end else if (issued) begin
                        state_q <= StWaitAck;
                    end
                end

                StRespond: begin
                    if (bus.i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_busy            = (state_q != StIdle);
    assign bus.o_cmd_ready   = (state_q == StIdle);
    assign bus.o_wb_cyc      = cyc_q;
    assign bus.o_wb_stb      = stb_q;
    assign bus.o_wb_we       = we_q;
    assign bus.o_wb_addr     = addr_q;
    assign bus.o_wb_dat      = wdata_q;
    assign bus.o_wb_sel      = sel_q;
    assign bus.o_rsp_valid   = rsp_valid_q;
    assign bus.o_rsp_rdata   = rsp_rdata_q;
    assign bus.o_rsp_err     = rsp_err_q;
    assign bus.o_rsp_timeout = rsp_timeout_q;

endmodule
